// File: rtl/lock_pkg.sv
// Shared types and default timing for the code-lock supervisor.
//   state_t : supervisor FSM states
//   key_t   : {key1, key0} keypad encodings
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    WAIT     = 3'd2,
    CHECK    = 3'd3,
    UNLOCKED = 3'd4,
    LOCKOUT  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    KEY_NONE   = 2'b00,
    KEY_DIGIT0 = 2'b01,
    KEY_DIGIT1 = 2'b10,
    KEY_BOTH   = 2'b11
  } key_t;

  localparam int unsigned DEF_CODE_LEN       = 6;
  localparam int unsigned DEF_MAX_FAILS      = 3;
  localparam int unsigned DEF_UNLOCK_CYCLES  = 1000;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 10000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 5000;

  // Largest of three cycle counts; sizes the shared phase timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the timeout, unlock and lockout phases.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load         : load load_value this cycle (overrides counting)
//   load_value   : count to load; done_c rises load_value cycles later
//   done_c       : counter has reached zero (combinational decode)
module lock_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         done_c
);

  logic [W-1:0] count;

  // Saturates at zero so done_c stays asserted until the next load.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/lock_controller.sv
// Attempt sequencer and supervisor in front of the serial code-lock core.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   key0, key1            : one-cycle digit pulses from the debounced keypad
//   relock                : ends the unlock hold early
//   lock_out              : match output of the lock core
//   lock_inp0/1           : registered digit strobes to the lock core
//   lock_reset            : registered synchronous clear to the lock core
//   unlocked, alarm       : decoded from the state register
//   fail_pulse            : high during a CHECK cycle that sees no match
//   fail_count            : consecutive failed attempts (saturating)
//   digit_count           : digits entered in the current attempt
module lock_controller
  import lock_pkg::*;
#(
  parameter int unsigned CODE_LEN       = DEF_CODE_LEN,
  parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
  parameter int unsigned UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          key0,
  input  logic                          key1,
  input  logic                          relock,
  input  logic                          lock_out,
  output logic                          lock_inp0,
  output logic                          lock_inp1,
  output logic                          lock_reset,
  output logic                          unlocked,
  output logic                          alarm,
  output logic                          fail_pulse,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
  output logic [$clog2(CODE_LEN+1)-1:0]  digit_count
);

  localparam int unsigned DW   = $clog2(CODE_LEN + 1);
  localparam int unsigned FW   = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMAX = max3(UNLOCK_CYCLES, LOCKOUT_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_t         state;
  key_t           key_c;
  logic           key_ok_c;
  logic [DW-1:0]  dc_next_c;
  logic [FW-1:0]  fc_next_c;
  logic           tmr_load_c;
  logic [TW-1:0]  tmr_value_c;
  logic           tmr_done_c;

  // A press counts only when exactly one key is high and we are taking digits.
  assign key_c     = key_t'({key1, key0});
  assign key_ok_c  = ((key_c == KEY_DIGIT0) || (key_c == KEY_DIGIT1)) &&
                     ((state == IDLE) || (state == ENTRY));
  assign dc_next_c = (digit_count == DW'(CODE_LEN))  ? digit_count : digit_count + DW'(1);
  assign fc_next_c = (fail_count  == FW'(MAX_FAILS)) ? fail_count  : fail_count  + FW'(1);

  // Timer reload: every accepted digit restarts the idle timeout; leaving
  // CHECK arms either the unlock hold or the lockout (unused on CHECK->IDLE).
  always_comb begin
    tmr_load_c  = 1'b0;
    tmr_value_c = '0;
    if (key_ok_c) begin
      tmr_load_c  = 1'b1;
      tmr_value_c = TW'(TIMEOUT_CYCLES - 1);
    end else if (state == CHECK) begin
      tmr_load_c  = 1'b1;
      tmr_value_c = lock_out ? TW'(UNLOCK_CYCLES - 1) : TW'(LOCKOUT_CYCLES - 1);
    end
  end

  lock_timer #(.W(TW)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (tmr_load_c),
    .load_value (tmr_value_c),
    .done_c     (tmr_done_c)
  );

  // Supervisor FSM; lock_reset is set on every transition into IDLE so the
  // lock core is cleared for the whole time we wait for the first digit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      lock_inp0   <= 1'b0;
      lock_inp1   <= 1'b0;
      lock_reset  <= 1'b1;
      fail_count  <= '0;
      digit_count <= '0;
    end else begin
      lock_inp0 <= 1'b0;
      lock_inp1 <= 1'b0;
      case (state)
        IDLE, ENTRY: begin
          if (key_ok_c) begin
            lock_inp0   <= key0;
            lock_inp1   <= key1;
            lock_reset  <= 1'b0;
            digit_count <= dc_next_c;
            state       <= (dc_next_c == DW'(CODE_LEN)) ? WAIT : ENTRY;
          end else if (state == IDLE) begin
            lock_reset  <= 1'b1;
            digit_count <= '0;
          end else if (tmr_done_c) begin
            state       <= IDLE;
            lock_reset  <= 1'b1;
            digit_count <= '0;
          end
        end
        WAIT: begin
          state <= CHECK;
        end
        CHECK: begin
          digit_count <= '0;
          if (lock_out) begin
            fail_count <= '0;
            state      <= UNLOCKED;
          end else begin
            fail_count <= fc_next_c;
            if (fc_next_c == FW'(MAX_FAILS)) begin
              state <= LOCKOUT;
            end else begin
              state      <= IDLE;
              lock_reset <= 1'b1;
            end
          end
        end
        UNLOCKED: begin
          if (relock || tmr_done_c) begin
            state      <= IDLE;
            lock_reset <= 1'b1;
          end
        end
        LOCKOUT: begin
          if (tmr_done_c) begin
            state      <= IDLE;
            lock_reset <= 1'b1;
            fail_count <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          lock_reset  <= 1'b1;
          digit_count <= '0;
        end
      endcase
    end
  end

  assign unlocked   = (state == UNLOCKED);
  assign alarm      = (state == LOCKOUT);
  // Must be visible in the CHECK cycle itself, while lock_out is being sampled.
  assign fail_pulse = (state == CHECK) && !lock_out;

endmodule

// File: tb/tb_lock_controller.sv
// Directed self-checking bench for lock_controller with a behavioural lock core.
module tb_lock_controller;

  logic       clock;
  logic       reset;
  logic       key0;
  logic       key1;
  logic       relock;
  logic       lock_out;
  logic       lock_inp0;
  logic       lock_inp1;
  logic       lock_reset;
  logic       unlocked;
  logic       alarm;
  logic       fail_pulse;
  logic [1:0] fail_count;
  logic [2:0] digit_count;

  int n_cmp = 0;
  int n_err = 0;

  // Bit i holds digit i of an attempt.
  logic [5:0] code_good;
  logic [5:0] code_bad1;
  logic [5:0] code_bad2;
  logic [2:0] lk_pos;

  lock_controller #(
    .CODE_LEN       (6),
    .MAX_FAILS      (3),
    .UNLOCK_CYCLES  (8),
    .LOCKOUT_CYCLES (16),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key0        (key0),
    .key1        (key1),
    .relock      (relock),
    .lock_out    (lock_out),
    .lock_inp0   (lock_inp0),
    .lock_inp1   (lock_inp1),
    .lock_reset  (lock_reset),
    .unlocked    (unlocked),
    .alarm       (alarm),
    .fail_pulse  (fail_pulse),
    .fail_count  (fail_count),
    .digit_count (digit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural serial lock core: matches after 0,1,1,0,0,1.
  always @(posedge clock) begin
    if (lock_reset) begin
      lk_pos <= 3'd0;
    end else if (lock_inp0 ^ lock_inp1) begin
      if (lk_pos < 3'd6 && lock_inp1 == code_good[lk_pos])
        lk_pos <= lk_pos + 3'd1;
      else
        lk_pos <= (lock_inp1 == code_good[0]) ? 3'd1 : 3'd0;
    end
  end
  assign lock_out = (lk_pos == 3'd6);

  // One clock cycle with the given inputs; returns #1 after the edge.
  task automatic step(input logic k0, input logic k1, input logic rl);
    key0 = k0; key1 = k1; relock = rl;
    @(posedge clock); #1;
    key0 = 1'b0; key1 = 1'b0; relock = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Six back-to-back digits; each strobe appears the cycle after its key.
  task automatic enter_code(input logic [5:0] code);
    for (int i = 0; i < 6; i++) begin
      step(!code[i], code[i], 1'b0);
      n_cmp++; if ({lock_inp1, lock_inp0} !== {code[i], !code[i]}) begin n_err++;
        $display("FAIL strobe[%0d] got %b want %b", i, {lock_inp1, lock_inp0}, {code[i], !code[i]}); end
      n_cmp++; if (digit_count !== 3'(i + 1)) begin n_err++;
        $display("FAIL digit_count[%0d] got %0d want %0d", i, digit_count, i + 1); end
      n_cmp++; if (lock_reset !== 1'b0) begin n_err++;
        $display("FAIL lock_reset_entry[%0d] got %b want 0", i, lock_reset); end
    end
  endtask

  // WAIT -> CHECK (fail_pulse) -> outcome cycle (unlocked).
  task automatic finish_check(input logic exp_match);
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (fail_pulse !== !exp_match) begin n_err++;
      $display("FAIL fail_pulse_check got %b want %b", fail_pulse, !exp_match); end
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if (unlocked !== exp_match) begin n_err++;
      $display("FAIL unlocked_outcome got %b want %b", unlocked, exp_match); end
    n_cmp++; if (fail_pulse !== 1'b0) begin n_err++;
      $display("FAIL fail_pulse_after got %b want 0", fail_pulse); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if ({lock_inp0, lock_inp1, unlocked, alarm, fail_pulse} !== 5'b0) begin n_err++;
      $display("FAIL reset_outputs got %b want 00000", {lock_inp0, lock_inp1, unlocked, alarm, fail_pulse}); end
    n_cmp++; if (lock_reset !== 1'b1) begin n_err++;
      $display("FAIL reset_lock_reset got %b want 1", lock_reset); end
    n_cmp++; if ({fail_count, digit_count} !== 5'b0) begin n_err++;
      $display("FAIL reset_counts got %0d/%0d want 0/0", fail_count, digit_count); end
    reset = 1'b0;
  endtask

  task automatic test_unlock;
    enter_code(code_good);
    finish_check(1'b1);
    n_cmp++; if (fail_count !== 2'd0) begin n_err++;
      $display("FAIL unlock_fail_count got %0d want 0", fail_count); end
    for (int c = 9; c <= 15; c++) begin
      step(1'b0, 1'b0, 1'b0);
      n_cmp++; if (unlocked !== 1'b1) begin n_err++;
        $display("FAIL unlock_hold[%0d] got %b want 1", c, unlocked); end
    end
    step(1'b0, 1'b0, 1'b0);
    n_cmp++; if ({unlocked, lock_reset} !== 2'b01) begin n_err++;
      $display("FAIL unlock_end got %b want 01", {unlocked, lock_reset}); end
  endtask

  task automatic test_wrong_code;
    enter_code(code_bad1);
    finish_check(1'b0);
    n_cmp++; if (fail_count !== 2'd1) begin n_err++;
      $display("FAIL wrong_fail_count got %0d want 1", fail_count); end
    n_cmp++; if ({lock_reset, digit_count} !== 4'b1000) begin n_err++;
      $display("FAIL wrong_idle got %b want 1000", {lock_reset, digit_count}); end
  endtask

  task automatic test_lockout;
    enter_code(code_bad1);
    finish_check(1'b0);
    n_cmp++; if (fail_count !== 2'd2) begin n_err++;
      $display("FAIL lockout_fc2 got %0d want 2", fail_count); end
    enter_code(code_bad2);
    finish_check(1'b0);
    n_cmp++; if ({alarm, fail_count} !== 3'b111) begin n_err++;
      $display("FAIL lockout_enter got %b want 111", {alarm, fail_count}); end
    for (int c = 9; c <= 23; c++) begin
      step(c[0], !c[0], 1'b0);
      n_cmp++; if ({alarm, lock_inp1, lock_inp0} !== 3'b100) begin n_err++;
        $display("FAIL lockout_hold[%0d] got %b want 100", c, {alarm, lock_inp1, lock_inp0}); end
    end
    step(1'b0, 1'b1, 1'b0);
    n_cmp++; if ({alarm, lock_inp1, lock_reset} !== 3'b001) begin n_err++;
      $display("FAIL lockout_exit got %b want 001", {alarm, lock_inp1, lock_reset}); end
    n_cmp++; if (fail_count !== 2'd0) begin n_err++;
      $display("FAIL lockout_fc_clear got %0d want 0", fail_count); end
    enter_code(code_good);
    finish_check(1'b1);
    idle(8);
  endtask

  task automatic test_timeout;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(9);
    n_cmp++; if ({lock_reset, digit_count} !== 4'b0010) begin n_err++;
      $display("FAIL timeout_early got %b want 0010", {lock_reset, digit_count}); end
    idle(1);
    n_cmp++; if ({lock_reset, digit_count} !== 4'b1000) begin n_err++;
      $display("FAIL timeout_idle got %b want 1000", {lock_reset, digit_count}); end
    n_cmp++; if ({fail_pulse, fail_count} !== 3'b000) begin n_err++;
      $display("FAIL timeout_fail got %b want 000", {fail_pulse, fail_count}); end
    enter_code(code_good);
    finish_check(1'b1);
    idle(8);
  endtask

  task automatic test_both_keys;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    n_cmp++; if ({lock_inp1, lock_inp0, digit_count} !== 5'b00011) begin n_err++;
      $display("FAIL both_keys got %b want 00011", {lock_inp1, lock_inp0, digit_count}); end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_cmp++; if ({lock_inp1, digit_count} !== 4'b1110) begin n_err++;
      $display("FAIL both_last got %b want 1110", {lock_inp1, digit_count}); end
    finish_check(1'b1);
    idle(8);
  endtask

  task automatic test_relock_reset;
    enter_code(code_good);
    finish_check(1'b1);
    step(1'b0, 1'b0, 1'b1);
    n_cmp++; if ({unlocked, lock_reset} !== 2'b01) begin n_err++;
      $display("FAIL relock got %b want 01", {unlocked, lock_reset}); end
    enter_code(code_good);
    finish_check(1'b1);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    n_cmp++; if ({unlocked, lock_reset} !== 2'b01) begin n_err++;
      $display("FAIL reset_unlocked got %b want 01", {unlocked, lock_reset}); end
    enter_code(code_bad1);
    finish_check(1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    n_cmp++; if ({fail_count, digit_count, lock_inp0, lock_reset} !== 7'b0000001) begin n_err++;
      $display("FAIL reset_entry got %b want 0000001", {fail_count, digit_count, lock_inp0, lock_reset}); end
  endtask

  initial begin
    code_good = 6'b100110;
    code_bad1 = 6'b000110;
    code_bad2 = 6'b111111;
    reset = 1'b1; key0 = 1'b0; key1 = 1'b0; relock = 1'b0;
    test_reset;
    test_unlock;
    test_wrong_code;
    test_lockout;
    test_timeout;
    test_both_keys;
    test_relock_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
